unified_mem_arbiter: RTL
========================

Name: unified_mem_arbiter

Overview:
- Shares one single-ported, variable-latency unified memory between the pipeline's instruction-fetch port and its data-memory port.
- Sequences each access through a request/ack handshake and registers the returned data.
- Generates the fetch and data stall levels that feed the hazard unit's StallF/StallD/FlushE logic.
- Data access has fixed priority over fetch. A watchdog aborts memory accesses that never complete.

Parameters:
- ADDR_W, 32, address width of all ports
- DATA_W, 32, data width of all ports
- MAX_WAIT, 15, maximum cycles mem_req may stay high without mem_ack before abort (1..255)

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous reset, active-high
- if_req  input  1  fetch request level; held until if_valid
- if_addr  input  ADDR_W  fetch address (PCF)
- if_rdata  output  DATA_W  fetched instruction, registered
- if_valid  output  1  one-cycle completion pulse for fetch
- dm_req  input  1  data request level; held until dm_valid
- dm_we  input  1  1=store, 0=load
- dm_addr  input  ADDR_W  data address (ALUResultM)
- dm_wdata  input  DATA_W  store data (WriteDataM)
- dm_rdata  output  DATA_W  load data, registered
- dm_valid  output  1  one-cycle completion pulse for data
- stall_fetch  output  1  if_req & ~if_valid (combinational)
- stall_data  output  1  dm_req & ~dm_valid (combinational)
- mem_req  output  1  memory request, registered
- mem_we  output  1  memory write enable, registered
- mem_addr  output  ADDR_W  memory address, registered
- mem_wdata  output  DATA_W  memory write data, registered
- mem_rdata  input  DATA_W  memory read data, valid when mem_ack=1
- mem_ack  input  1  one-cycle completion from memory
- err  output  1  sticky watchdog error
- err_src  output  1  source of the first error: 0=fetch, 1=data

Behaviour:
- Reset (async): state IDLE. All outputs 0: if_rdata, dm_rdata, mem_* , err, err_src, valids. Watchdog counter 0. A reset mid-access drops mem_req immediately; the in-flight access is lost.
- States: IDLE, D_BUSY, F_BUSY, RESP.
- IDLE:
  - dm_req=1 -> D_BUSY. Latch dm_addr/dm_we/dm_wdata into mem_*; set mem_req=1.
  - else if_req=1 -> F_BUSY. Latch if_addr; mem_we=0; mem_req=1.
  - Both requests present -> data wins; fetch waits in IDLE until the next grant opportunity.
- D_BUSY / F_BUSY:
  - mem_req and mem_* held stable; counter increments each cycle without mem_ack.
  - mem_ack=1 -> mem_req=0, mem_we=0, counter cleared, go RESP.
  - Load/fetch capture mem_rdata into dm_rdata/if_rdata. A store leaves dm_rdata unchanged.
  - mem_ack while IDLE or RESP is ignored.
- Watchdog: counter reaches MAX_WAIT with no ack -> mem_req=0, go RESP, owner's rdata=0, err=1. err_src is set to the owner only if err was previously 0. err clears only on reset.
- RESP: pulse the owner's valid for exactly one cycle, then IDLE. The owner's req is not sampled while in RESP.
- Latency: ack in the first mem_req cycle gives req at cycle 0, mem_req at cycle 1, valid at cycle 2, next grant at cycle 3. Each extra wait cycle adds 1.
- Back-to-back data requests may starve fetch; this is acceptable because the pipeline is stalled on data.
- Address and data are passed unmodified; no alignment check.

Optional Feature:
- Macro: ARB_PERF_CNT_EN.
- Defined: adds outputs perf_fstall[31:0] and perf_dstall[31:0]. Each increments every cycle its stall output is 1, saturates at 0xFFFFFFFF, and resets to 0.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Fetch only: if_req=1, if_addr=0x40, mem_ack with mem_rdata=0x00500093 in the first mem_req cycle -> mem_addr=0x40 at cycle 1, if_valid=1 and if_rdata=0x00500093 at cycle 2, stall_fetch=1 at cycles 0-1 and 0 at cycle 2.
- Simultaneous: if_req=1 and dm_req=1 (load at 0x100, mem returns 0xDEADBEEF after 3 wait cycles) -> data granted first; dm_valid with dm_rdata=0xDEADBEEF; fetch granted in the following IDLE cycle.
- Store: dm_we=1, dm_addr=0x20, dm_wdata=0x1234 -> mem_we=1, mem_wdata=0x1234 until ack; dm_rdata unchanged; dm_valid pulses once.
- Watchdog: fetch access, mem_ack never asserted, MAX_WAIT=15 -> mem_req drops after 15 cycles; if_valid=1 with if_rdata=0; err=1, err_src=0; a later data timeout leaves err_src=0.
- Reset mid-access: rst pulsed while in D_BUSY -> mem_req=0 in the same cycle, all outputs 0; a late mem_ack after reset is ignored.
- ARB_PERF_CNT_EN defined: a data access taking 4 cycles to dm_valid -> perf_dstall=4, perf_fstall=0.

Source files
------------

// File: rtl/unified_mem_arbiter.sv
// Arbitrates one variable-latency unified memory between fetch and data ports; data has priority.
// Optional ARB_PERF_CNT_EN adds saturating stall-cycle counters perf_fstall/perf_dstall.
module unified_mem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_valid,
  output logic              stall_fetch,
  output logic              stall_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
`ifdef ARB_PERF_CNT_EN
  output logic [31:0]       perf_fstall,
  output logic [31:0]       perf_dstall,
`endif
  output logic              err,
  output logic              err_src
);

  typedef enum logic [1:0] {IDLE, D_BUSY, F_BUSY, RESP} state_e;

  localparam logic [7:0] WD_LAST = 8'(MAX_WAIT - 1);

  state_e            state_q, state_d;
  logic              own_q, own_d;      // 1 = data port owns the access
  logic [7:0]        cnt_q, cnt_d;
  logic              mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d, dm_rdata_q, dm_rdata_d;
  logic              err_q, err_d, err_src_q, err_src_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      own_q       <= 1'b0;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      err_q       <= 1'b0;
      err_src_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      own_q       <= own_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      err_q       <= err_d;
      err_src_q   <= err_src_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    own_d       = own_q;
    cnt_d       = cnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    err_d       = err_q;
    err_src_d   = err_src_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (dm_req) begin
          state_d     = D_BUSY;
          own_d       = 1'b1;
          mem_req_d   = 1'b1;
          mem_we_d    = dm_we;
          mem_addr_d  = dm_addr;
          mem_wdata_d = dm_wdata;
        end else if (if_req) begin
          state_d    = F_BUSY;
          own_d      = 1'b0;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = if_addr;
        end
      end
      D_BUSY, F_BUSY: begin
        // An ack in the last allowed cycle still completes normally.
        if (mem_ack) begin
          state_d   = RESP;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          cnt_d     = '0;
          if (!own_q)         if_rdata_d = mem_rdata;
          else if (!mem_we_q) dm_rdata_d = mem_rdata;
        end else if (cnt_q == WD_LAST) begin
          state_d   = RESP;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          cnt_d     = '0;
          err_d     = 1'b1;
          if (!err_q) err_src_d = own_q;
          if (own_q) dm_rdata_d = '0;
          else       if_rdata_d = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign if_valid    = (state_q == RESP) && !own_q;
  assign dm_valid    = (state_q == RESP) &&  own_q;
  assign stall_fetch = if_req & ~if_valid;
  assign stall_data  = dm_req & ~dm_valid;
  assign if_rdata    = if_rdata_q;
  assign dm_rdata    = dm_rdata_q;
  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign err         = err_q;
  assign err_src     = err_src_q;

`ifdef ARB_PERF_CNT_EN
  logic [31:0] pf_q, pd_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pf_q <= '0;
      pd_q <= '0;
    end else begin
      if (stall_fetch && pf_q != 32'hFFFF_FFFF) pf_q <= pf_q + 32'd1;
      if (stall_data  && pd_q != 32'hFFFF_FFFF) pd_q <= pd_q + 32'd1;
    end
  end
  assign perf_fstall = pf_q;
  assign perf_dstall = pd_q;
`endif

endmodule
